// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet transmitter feeding the router input port. A host hands over a
// command (destination address, payload length) and then the payload bytes.
// The whole payload is buffered internally. The packet is then streamed to the
// router as header, payload, parity. Router busy stalls are honoured, and a
// stall that lasts too long aborts the packet.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   cmd_valid  host command valid
//   cmd_ready  command accept (IDLE only, low while in reset)
//   cmd_addr   destination port 0..2 (3 is illegal)
//   cmd_len    payload length 1..63 (0 is illegal)
//   pay_valid  host payload byte valid
//   pay_ready  payload accept (FILL only, low while in reset)
//   pay_data   payload byte
//   busy       router busy; the byte on data_out is consumed on edges with busy=0
//   data_out   registered byte to the router
//   pkt_valid  registered; high for header and payload, low for parity
//   tx_done    one-cycle pulse after the parity byte is consumed
//   tx_abort   one-cycle pulse after a busy timeout
// -----------------------------------------------------------------------------
module router_pkt_tx #(
   parameter int BUSY_TIMEOUT = 32,
   parameter int IDLE_GAP     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic       pay_valid,
   output logic       pay_ready,
   input  logic [7:0] pay_data,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       tx_done,
   output logic       tx_abort
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam int GW = $clog2(IDLE_GAP + 1);
   // Abort fires on the busy edge that would take the counter to BUSY_TIMEOUT.
   localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_HEADER  = 3'd2,
      S_PAYLOAD = 3'd3,
      S_PARITY  = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   // Header layout on the wire: length in the upper six bits, port in the lower two.
   function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
      return {len, addr};
   endfunction

   // Running parity accumulation over the header and payload bytes.
   function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t        state_r;
   logic [1:0]    addr_r;
   logic [5:0]    len_r;
   logic [5:0]    wr_ptr_r;
   logic [5:0]    rd_ptr_r;
   logic [7:0]    parity_r;
   logic [TW-1:0] to_cnt_r;
   logic [GW-1:0] gap_cnt_r;
   logic [7:0]    pay_mem [0:63];

   logic          fill_hs_s;
   logic          cmd_legal_s;

   // Handshake readiness is a pure state decode, gated off while in reset.
   assign cmd_ready   = rst & (state_r == S_IDLE);
   assign pay_ready   = rst & (state_r == S_FILL);
   assign fill_hs_s   = pay_valid & pay_ready;
   assign cmd_legal_s = (cmd_len != 6'd0) && (cmd_addr != 2'd3);

   // Payload buffer: written in FILL and flushed by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++) begin
            pay_mem[i] <= 8'h00;
         end
      end else if (fill_hs_s) begin
         pay_mem[wr_ptr_r] <= pay_data;
      end
   end

   // Transmit FSM with registered byte stream, pulses and busy timeout.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         addr_r    <= 2'd0;
         len_r     <= 6'd0;
         wr_ptr_r  <= 6'd0;
         rd_ptr_r  <= 6'd0;
         parity_r  <= 8'h00;
         to_cnt_r  <= '0;
         gap_cnt_r <= '0;
         data_out  <= 8'h00;
         pkt_valid <= 1'b0;
         tx_done   <= 1'b0;
         tx_abort  <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_abort <= 1'b0;
         case (state_r)
            S_IDLE: begin
               data_out  <= 8'h00;
               pkt_valid <= 1'b0;
               to_cnt_r  <= '0;
               // Illegal commands are accepted (cmd_ready is high) and dropped.
               if (cmd_valid && cmd_legal_s) begin
                  addr_r   <= cmd_addr;
                  len_r    <= cmd_len;
                  parity_r <= make_header(cmd_addr, cmd_len);
                  wr_ptr_r <= 6'd0;
                  state_r  <= S_FILL;
               end
            end

            S_FILL: begin
               if (pay_valid) begin
                  parity_r <= parity_fold(parity_r, pay_data);
                  // The final byte does not advance wr_ptr, so len=63 stops at 62.
                  if (wr_ptr_r == len_r - 6'd1) begin
                     state_r   <= S_HEADER;
                     data_out  <= make_header(addr_r, len_r);
                     pkt_valid <= 1'b1;
                     to_cnt_r  <= '0;
                  end else begin
                     wr_ptr_r <= wr_ptr_r + 6'd1;
                  end
               end
            end

            S_HEADER, S_PAYLOAD, S_PARITY: begin
               if (busy) begin
                  if (to_cnt_r == TO_LAST) begin
                     state_r   <= S_GAP;
                     gap_cnt_r <= '0;
                     to_cnt_r  <= '0;
                     data_out  <= 8'h00;
                     pkt_valid <= 1'b0;
                     tx_abort  <= 1'b1;
                  end else begin
                     to_cnt_r <= to_cnt_r + TW'(1);
                  end
               end else begin
                  to_cnt_r <= '0;
                  if (state_r == S_HEADER) begin
                     state_r  <= S_PAYLOAD;
                     rd_ptr_r <= 6'd0;
                     data_out <= pay_mem[6'd0];
                  end else if (state_r == S_PAYLOAD) begin
                     if (rd_ptr_r == len_r - 6'd1) begin
                        state_r   <= S_PARITY;
                        data_out  <= parity_r;
                        pkt_valid <= 1'b0;
                     end else begin
                        rd_ptr_r <= rd_ptr_r + 6'd1;
                        data_out <= pay_mem[rd_ptr_r + 6'd1];
                     end
                  end else begin
                     state_r   <= S_GAP;
                     gap_cnt_r <= '0;
                     data_out  <= 8'h00;
                     pkt_valid <= 1'b0;
                     tx_done   <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               data_out  <= 8'h00;
               pkt_valid <= 1'b0;
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= S_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GW'(1);
               end
            end

            default: begin
               state_r   <= S_IDLE;
               data_out  <= 8'h00;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed bench for router_pkt_tx. Expected wire bytes (header, payload,
// parity) go onto a scoreboard queue when a packet is loaded. They are popped
// as the bench releases busy and the DUT consumes each byte.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_addr;
   logic [5:0] cmd_len;
   logic       pay_valid;
   logic       pay_ready;
   logic [7:0] pay_data;
   logic       busy;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_done;
   logic       tx_abort;

   typedef struct packed {
      logic [7:0] d;
      logic       pv;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] pay_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   router_pkt_tx #(.BUSY_TIMEOUT(32), .IDLE_GAP(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .pay_valid (pay_valid),
      .pay_ready (pay_ready),
      .pay_data  (pay_data),
      .busy      (busy),
      .data_out  (data_out),
      .pkt_valid (pkt_valid),
      .tx_done   (tx_done),
      .tx_abort  (tx_abort)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      while (cmd_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Pushes the expected wire image, then hands the command and pay_q to the DUT.
   // Returns at the negedge of the first HEADER cycle.
   task automatic load_packet(input logic [1:0] a, input logic [5:0] l);
      exp_t       e;
      logic [7:0] par;
      int         n;
      par  = {l, a};
      e.d  = par;
      e.pv = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < pay_q.size(); i++) begin
         e.d  = pay_q[i];
         e.pv = 1'b1;
         sb.push_back(e);
         par  = par ^ pay_q[i];
      end
      e.d  = par;
      e.pv = 1'b0;
      sb.push_back(e);
      send_cmd(a, l);
      for (int i = 0; i < pay_q.size(); i++) begin
         pay_valid = 1'b1;
         pay_data  = pay_q[i];
         n = 0;
         while (pay_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
         end
         check("pay_ready_wait", {31'd0, pay_ready}, 32'd1);
         check("fill_pkt_valid", {31'd0, pkt_valid}, 32'd0);
         @(negedge clk);
      end
      pay_valid = 1'b0;
   endtask

   // Streams the scoreboard out, holding busy high for stall_n cycles at stall_idx.
   task automatic drain(input int stall_idx, input int stall_n);
      exp_t e;
      int   pos;
      int   stalled;
      int   n;
      pos = 0;
      stalled = 0;
      n = 0;
      while (sb.size() > 0 && n < 400) begin
         e = sb[0];
         check("data_out", {24'd0, data_out}, {24'd0, e.d});
         check("pkt_valid", {31'd0, pkt_valid}, {31'd0, e.pv});
         if (pos == stall_idx && stalled < stall_n) begin
            busy = 1'b1;
            stalled++;
         end else begin
            busy = 1'b0;
            e = sb.pop_front();
            pos++;
         end
         @(negedge clk);
         n++;
      end
      busy = 1'b0;
      check("drain_bound", sb.size(), 32'd0);
      check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
      check("no_abort", {31'd0, tx_abort}, 32'd0);
      check("gap1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("tx_done_end", {31'd0, tx_done}, 32'd0);
      check("gap2_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_pv"}, {31'd0, pkt_valid}, 32'd0);
      check({tag, "_pay_ready"}, {31'd0, pay_ready}, 32'd0);
      check({tag, "_done"}, {31'd0, tx_done}, 32'd0);
      check({tag, "_abort"}, {31'd0, tx_abort}, 32'd0);
      check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = 2'd0;
      cmd_len   = 6'd0;
      pay_valid = 1'b0;
      pay_data  = 8'h00;
      busy      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check("rst_tx_abort", {31'd0, tx_abort}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // 1. Basic packet: expect 0x0D 0x11 0x22 0x33 then parity 0x0D
      pay_q = {8'h11, 8'h22, 8'h33};
      load_packet(2'd1, 6'd3);
      drain(-1, 0);

      // 2. Busy stall of 3 cycles while 0x22 (scoreboard index 2) is out
      load_packet(2'd1, 6'd3);
      drain(2, 3);

      // 3. Busy timeout from the first HEADER cycle, header 0x08
      pay_q = {8'hA5, 8'h5A};
      load_packet(2'd0, 6'd2);
      sb.delete();
      busy = 1'b1;
      check("to_header", {24'd0, data_out}, 32'h08);
      check("to_header_pv", {31'd0, pkt_valid}, 32'd1);
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         check("to_hold_pv", {31'd0, pkt_valid}, 32'd1);
         check("to_hold_abort", {31'd0, tx_abort}, 32'd0);
      end
      @(negedge clk);
      check("to_abort", {31'd0, tx_abort}, 32'd1);
      check("to_abort_pv", {31'd0, pkt_valid}, 32'd0);
      check("to_abort_data", {24'd0, data_out}, 32'd0);
      check("to_abort_no_done", {31'd0, tx_done}, 32'd0);
      busy = 1'b0;
      @(negedge clk);
      check("to_abort_end", {31'd0, tx_abort}, 32'd0);
      check("to_gap_no_done", {31'd0, tx_done}, 32'd0);
      check("to_gap_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("to_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // 4. Illegal commands: addr=3, then len=0
      send_cmd(2'd3, 6'd5);
      repeat (3) begin
         check_quiet("ill_addr");
         @(negedge clk);
      end
      send_cmd(2'd1, 6'd0);
      repeat (3) begin
         check_quiet("ill_len");
         @(negedge clk);
      end

      // 5. Maximum length packet, header 0xFE, payload 0x00..0x3E
      pay_q.delete();
      for (int i = 0; i < 63; i++) begin
         pay_q.push_back(8'(i));
      end
      load_packet(2'd2, 6'd63);
      drain(-1, 0);

      // 6. Reset while the 2nd payload byte is on data_out
      pay_q = {8'h41, 8'h42, 8'h43, 8'h44};
      load_packet(2'd1, 6'd4);
      sb.delete();
      busy = 1'b0;
      check("rs_header", {24'd0, data_out}, 32'h11);
      @(negedge clk);
      check("rs_byte0", {24'd0, data_out}, 32'h41);
      @(negedge clk);
      check("rs_byte1", {24'd0, data_out}, 32'h42);
      rst = 1'b0;
      @(negedge clk);
      check("rs_pv", {31'd0, pkt_valid}, 32'd0);
      check("rs_data", {24'd0, data_out}, 32'd0);
      check("rs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rs_pay_ready", {31'd0, pay_ready}, 32'd0);
      check("rs_done", {31'd0, tx_done}, 32'd0);
      @(negedge clk);
      check("rs_cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rs_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rs_idle_pv", {31'd0, pkt_valid}, 32'd0);

      // Clean packet after the mid-packet reset
      pay_q = {8'hC3, 8'h3C, 8'h99};
      load_packet(2'd2, 6'd3);
      drain(1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter that drives the router input port (data_out/pkt_valid into the router, busy back from the router).
- Accepts a command (destination address, payload length) and the payload bytes from a host, and buffers the whole payload internally.
- Then emits the packet as header byte, payload bytes, parity byte, honouring router busy stalls.
- Used as the on-chip traffic source for the 1x3 router and in subsystem benches.

Parameters:
BUSY_TIMEOUT, 32, consecutive busy-high cycles during transmission after which the packet is aborted.
IDLE_GAP, 2, cycles spent in GAP after a packet completes or aborts, before a new command is accepted (minimum 1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
cmd_valid  in  1  host command valid.
cmd_ready  out  1  high only in IDLE (and rst high); handshake = cmd_valid & cmd_ready.
cmd_addr  in  2  destination port 0..2; 3 is illegal.
cmd_len  in  6  payload length in bytes, 1..63; 0 is illegal.
pay_valid  in  1  host payload byte valid.
pay_ready  out  1  high only in FILL.
pay_data  in  8  payload byte.
busy  in  1  router busy; a byte on data_out is consumed on any edge where busy=0.
data_out  out  8  byte to router.
pkt_valid  out  1  high for header and payload bytes, low for the parity byte.
tx_done  out  1  one-cycle pulse when the parity byte is consumed.
tx_abort  out  1  one-cycle pulse on busy timeout.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, all pointers, parity and counters = 0; data_out=0, pkt_valid=0, tx_done=0, tx_abort=0. cmd_ready and pay_ready are 0 while rst=0. Reset mid-packet abandons it immediately (pkt_valid low the next cycle) and flushes buffer contents.
- Storage: 64x8 buffer, 6-bit wr_ptr and rd_ptr, 8-bit parity register, timeout counter of width clog2(BUSY_TIMEOUT+1), gap counter.
- Header byte = {cmd_len[5:0], cmd_addr[1:0]}. Parity = XOR of header and all payload bytes.
- IDLE:
  - Command handshake with len 0 or addr 3: command is consumed and discarded; no traffic, no pulse; state stays IDLE.
  - Legal command: latch addr/len, parity <= header, wr_ptr <= 0, go to FILL.
- FILL:
  - pay_ready=1. Each pay_valid & pay_ready handshake writes buf[wr_ptr], increments wr_ptr and XORs the byte into parity.
  - The handshake of byte number len goes to HEADER. The host may stall indefinitely; pkt_valid stays 0.
- HEADER: data_out=header, pkt_valid=1. An edge with busy=0 goes to PAYLOAD with rd_ptr=0. busy=1 holds the state.
- PAYLOAD:
  - data_out=buf[rd_ptr], pkt_valid=1, stable while busy=1.
  - An edge with busy=0 increments rd_ptr. If rd_ptr==len-1, go to PARITY instead.
  - pkt_valid never drops between header and the last payload byte.
- PARITY: data_out=parity, pkt_valid=0. An edge with busy=0 pulses tx_done the next cycle and goes to GAP.
- GAP: data_out=0, pkt_valid=0. After IDLE_GAP cycles, go to IDLE.
- Output timing:
  - data_out and pkt_valid are registered and update on the same edge as the state/pointer change.
  - Each byte is therefore present from the first cycle of its state.
  - No combinational path exists from busy to data_out.
- Timeout:
  - In HEADER, PAYLOAD or PARITY, the counter increments each cycle busy=1 and clears on busy=0 or on a state change.
  - When it reaches BUSY_TIMEOUT: pkt_valid<=0 and data_out<=0, tx_abort pulses for 1 cycle, then GAP. No tx_done is issued for that packet.
- Simultaneous events: tx_done and tx_abort are mutually exclusive. A command presented during FILL through GAP waits (cmd_ready=0).
- Max length 63: wr_ptr and rd_ptr reach 62 without wrapping. The buffer is reused per packet and is not cleared.

Test Plan:
1. Basic packet: cmd addr=1, len=3; payload 0x11,0x22,0x33; busy=0.
   -> data_out 0x0D(pv=1), 0x11, 0x22, 0x33(pv=1), 0x0D(pv=0) on consecutive cycles.
   -> tx_done 1 cycle after the parity byte; cmd_ready returns after 2 GAP cycles.
2. Busy stall: as in 1, busy=1 for 3 cycles while 0x22 is on data_out.
   -> 0x22 held 4 cycles, pkt_valid stays 1, stream otherwise unchanged.
3. Timeout: addr=0, len=2; busy held 1 from the first HEADER cycle.
   -> after 32 busy cycles tx_abort pulses, pkt_valid=0, no tx_done; the next command is accepted after GAP.
4. Illegal commands: len=0 or addr=3.
   -> consumed with cmd_ready=1, no pkt_valid, no pulses, state IDLE.
5. Max length: addr=2, len=63, payload 0x00..0x3E.
   -> header 0xFE, 63 payload bytes in order, parity = 0xFE ^ XOR(0x00..0x3E), tx_done.
6. Reset mid-payload: rst=0 on the 2nd payload byte.
   -> next cycle pkt_valid=0, data_out=0, cmd_ready=0 while rst low; after rst=1, state IDLE and cmd_ready=1.
